// File: rtl/bt656_pkg.sv
// rtl/bt656_pkg.sv - BT.656 constants, XY field positions and protection-bit helper.
// Shared between the BT.656 transmitter and receiver.
package bt656_pkg;

   localparam logic [7:0] PRE_FF = 8'hFF;
   localparam logic [7:0] PRE_00 = 8'h00;

   localparam int XY_ONE_BIT = 7;
   localparam int XY_F_BIT   = 6;
   localparam int XY_V_BIT   = 5;
   localparam int XY_H_BIT   = 4;

   localparam logic [7:0] BLANK_C = 8'h80;
   localparam logic [7:0] BLANK_Y = 8'h10;

   typedef enum logic [2:0] {
      ST_SEARCH,
      ST_GOT_FF,
      ST_GOT_00A,
      ST_GOT_00B,
      ST_ACTIVE
   } rx_state_t;

   // Protection bits P3..P0 carried in the low nibble of XY.
   function automatic logic [3:0] prot_bits(input logic f, input logic v, input logic h);
      return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
   endfunction

endpackage

// File: rtl/bt656_xy_check.sv
// rtl/bt656_xy_check.sv - combinational XY decode and protection-bit validation.
module bt656_xy_check
   import bt656_pkg::*;
(
   input  logic [7:0] xy,
   output logic       valid,
   output logic       f,
   output logic       v,
   output logic       h
);

   assign f = xy[XY_F_BIT];
   assign v = xy[XY_V_BIT];
   assign h = xy[XY_H_BIT];

   assign valid = xy[XY_ONE_BIT] && (xy[3:0] == prot_bits(f, v, h));

endmodule

// File: rtl/bt656_rx.sv
// rtl/bt656_rx.sv - BT.656 receiver: locks to FF 00 00 XY codes and emits Cb/Y0/Cr/Y1 pairs.
module bt656_rx
   import bt656_pkg::*;
#(
   parameter int HACT_BYTES = 1440,
   parameter int LINE_W     = 11,
   parameter int PIX_W      = 11
) (
   input  logic              i_SysClock,
   input  logic              i_Reset,
   input  logic              i_DataEn,
   input  logic [7:0]        i_Data,
   output logic [7:0]        o_Cb,
   output logic [7:0]        o_Y0,
   output logic [7:0]        o_Cr,
   output logic [7:0]        o_Y1,
   output logic              o_PairValid,
   output logic              o_Fsignal,
   output logic              o_Vsignal,
   output logic              o_Hsignal,
   output logic              o_EavPulse,
   output logic              o_SavPulse,
   output logic [LINE_W-1:0] o_LineCount,
   output logic [PIX_W-1:0]  o_PairCount,
   output logic              o_Locked,
   output logic              o_SyncError,
   output logic              o_LenError
);

   localparam logic [PIX_W-1:0]  HACT     = PIX_W'(HACT_BYTES);
   localparam logic [PIX_W-1:0]  BYTE_MAX = '1;
   localparam logic [LINE_W-1:0] LINE_MAX = '1;

   rx_state_t         state;
   rx_state_t         state_nx;
   logic              xy_valid;
   logic              xy_f;
   logic              xy_v;
   logic              xy_h;
   logic              xy_take;
   logic              act_take;
   logic              field_restart;
   logic [PIX_W-1:0]  byte_cnt;
   logic [7:0]        cb_hold;
   logic [7:0]        y0_hold;
   logic [7:0]        cr_hold;
   logic              last_eav;
   logic              sav_v0;

   bt656_xy_check u_xy_check (
      .xy    (i_Data),
      .valid (xy_valid),
      .f     (xy_f),
      .v     (xy_v),
      .h     (xy_h)
   );

   always_ff @(posedge i_SysClock or posedge i_Reset) begin
      if (i_Reset) begin
         state <= ST_SEARCH;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      xy_take  = 1'b0;
      act_take = 1'b0;
      if (i_DataEn) begin
         case (state)
            ST_SEARCH: begin
               if (i_Data == PRE_FF) state_nx = ST_GOT_FF;
            end
            ST_GOT_FF: begin
               if (i_Data == PRE_00)      state_nx = ST_GOT_00A;
               else if (i_Data != PRE_FF) state_nx = ST_SEARCH;
            end
            ST_GOT_00A: begin
               if (i_Data == PRE_00)      state_nx = ST_GOT_00B;
               else if (i_Data == PRE_FF) state_nx = ST_GOT_FF;
               else                       state_nx = ST_SEARCH;
            end
            ST_GOT_00B: begin
               xy_take  = 1'b1;
               state_nx = (xy_valid && !xy_h && !xy_v) ? ST_ACTIVE : ST_SEARCH;
            end
            ST_ACTIVE: begin
               // FF can never be video data, so it always opens a new preamble.
               if (i_Data == PRE_FF) state_nx = ST_GOT_FF;
               else                  act_take = 1'b1;
            end
            default: state_nx = ST_SEARCH;
         endcase
      end
   end

   // A field starts when F changes, or when vertical blanking ends in field 1.
   assign field_restart = (xy_f != o_Fsignal) || (o_Vsignal && !xy_v && !xy_f);

   always_ff @(posedge i_SysClock or posedge i_Reset) begin
      if (i_Reset) begin
         o_Cb        <= '0;
         o_Y0        <= '0;
         o_Cr        <= '0;
         o_Y1        <= '0;
         o_PairValid <= 1'b0;
         o_Fsignal   <= 1'b0;
         o_Vsignal   <= 1'b1;
         o_Hsignal   <= 1'b1;
         o_EavPulse  <= 1'b0;
         o_SavPulse  <= 1'b0;
         o_LineCount <= '0;
         o_PairCount <= '0;
         o_Locked    <= 1'b0;
         o_SyncError <= 1'b0;
         o_LenError  <= 1'b0;
         byte_cnt    <= '0;
         cb_hold     <= '0;
         y0_hold     <= '0;
         cr_hold     <= '0;
         last_eav    <= 1'b0;
         sav_v0      <= 1'b0;
      end else begin
         o_PairValid <= 1'b0;
         o_EavPulse  <= 1'b0;
         o_SavPulse  <= 1'b0;
         o_SyncError <= 1'b0;
         o_LenError  <= 1'b0;

         if (xy_take) begin
            if (!xy_valid) begin
               o_SyncError <= 1'b1;
               o_Locked    <= 1'b0;
            end else begin
               o_Fsignal <= xy_f;
               o_Vsignal <= xy_v;
               o_Hsignal <= xy_h;
               if (xy_h) begin
                  o_EavPulse <= 1'b1;
                  last_eav   <= 1'b1;
                  sav_v0     <= 1'b0;
                  if (sav_v0 && (byte_cnt != HACT)) o_LenError <= 1'b1;
                  if (field_restart)                o_LineCount <= '0;
                  else if (o_LineCount != LINE_MAX) o_LineCount <= o_LineCount + LINE_W'(1);
               end else begin
                  o_SavPulse  <= 1'b1;
                  o_PairCount <= '0;
                  byte_cnt    <= '0;
                  sav_v0      <= !xy_v;
                  last_eav    <= 1'b0;
                  if (last_eav) o_Locked <= 1'b1;
               end
            end
         end

         if (act_take) begin
            if (byte_cnt != BYTE_MAX) byte_cnt <= byte_cnt + PIX_W'(1);
            if (byte_cnt < HACT) begin
               case (byte_cnt[1:0])
                  2'd0: cb_hold <= i_Data;
                  2'd1: y0_hold <= i_Data;
                  2'd2: cr_hold <= i_Data;
                  default: begin
                     o_Cb        <= cb_hold;
                     o_Y0        <= y0_hold;
                     o_Cr        <= cr_hold;
                     o_Y1        <= i_Data;
                     o_PairValid <= 1'b1;
                     o_PairCount <= o_PairCount + PIX_W'(1);
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_bt656_rx.sv
// tb/tb_bt656_rx.sv - randomized self-checking bench for bt656_rx against a stream-level model.
`timescale 1ns/1ps
module tb_bt656_rx;
   import bt656_pkg::*;

   localparam int HACT = 1440;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [7:0]  din = 8'h00;
   logic [7:0]  o_cb, o_y0, o_cr, o_y1;
   logic        o_pv, o_f, o_v, o_h, o_eav, o_sav, o_locked, o_se, o_le;
   logic [10:0] o_line, o_pair;

   bt656_rx #(.HACT_BYTES(HACT), .LINE_W(11), .PIX_W(11)) dut (
      .i_SysClock (clk),    .i_Reset    (rst),     .i_DataEn   (en),     .i_Data     (din),
      .o_Cb       (o_cb),   .o_Y0       (o_y0),    .o_Cr       (o_cr),   .o_Y1       (o_y1),
      .o_PairValid(o_pv),   .o_Fsignal  (o_f),     .o_Vsignal  (o_v),    .o_Hsignal  (o_h),
      .o_EavPulse (o_eav),  .o_SavPulse (o_sav),   .o_LineCount(o_line), .o_PairCount(o_pair),
      .o_Locked   (o_locked), .o_SyncError(o_se),  .o_LenError (o_le)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Valid XY codes indexed by {F,V,H}.
   logic [7:0] xy_tab [8] = '{8'h80, 8'h9D, 8'hAB, 8'hB6, 8'hC7, 8'hDA, 8'hEC, 8'hF1};

   // Reference model state, advanced once per enabled byte.
   logic [7:0]  hist [$];
   logic [7:0]  grp [4];
   bit          m_f, m_v, m_h, m_locked, m_last_eav, m_sav_v0, m_active;
   int          m_line, m_pair, m_cnt;
   bit          e_pv, e_eav, e_sav, e_se, e_le;
   logic [31:0] e_pair;
   int          pv_seen, le_seen, se_seen, sav_seen;
   int          gap_mode;

   task automatic model_reset();
      hist.delete();
      m_f = 0; m_v = 1; m_h = 1; m_locked = 0; m_last_eav = 0; m_sav_v0 = 0; m_active = 0;
      m_line = 0; m_pair = 0; m_cnt = 0;
      e_pv = 0; e_eav = 0; e_sav = 0; e_se = 0; e_le = 0; e_pair = '0;
   endtask

   task automatic model_xy(input logic [7:0] d);
      int idx;
      bit nf, nv, nh;
      idx = -1;
      for (int i = 0; i < 8; i++) if (xy_tab[i] == d) idx = i;
      if (idx < 0) begin
         e_se = 1; m_locked = 0;
         return;
      end
      nf = idx[2]; nv = idx[1]; nh = idx[0];
      if (nh) begin
         e_eav = 1;
         if (m_sav_v0 && m_cnt != HACT) e_le = 1;
         m_sav_v0 = 0;
         if (nf != m_f || (m_v && !nv && !nf)) m_line = 0;
         else if (m_line < 2047) m_line++;
         m_last_eav = 1;
      end else begin
         e_sav = 1; m_pair = 0; m_cnt = 0; m_sav_v0 = !nv;
         if (m_last_eav) m_locked = 1;
         m_last_eav = 0;
         m_active = !nv;
      end
      m_f = nf; m_v = nv; m_h = nh;
   endtask

   task automatic model_step(input bit e, input logic [7:0] d);
      e_pv = 0; e_eav = 0; e_sav = 0; e_se = 0; e_le = 0;
      if (!e) return;
      hist.push_back(d);
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4 && hist[0] == 8'hFF && hist[1] == 8'h00 && hist[2] == 8'h00) begin
         hist.delete();
         m_active = 0;
         model_xy(d);
      end else if (m_active) begin
         if (d == 8'hFF) m_active = 0;
         else begin
            if (m_cnt < HACT) begin
               grp[m_cnt % 4] = d;
               if (m_cnt % 4 == 3) begin
                  e_pv = 1; e_pair = {grp[0], grp[1], grp[2], grp[3]}; m_pair++;
               end
            end
            if (m_cnt < 2047) m_cnt++;
         end
      end
   endtask

   task automatic compare_all();
      check("pulses", 64'({o_pv, o_eav, o_sav, o_se, o_le}), 64'({e_pv, e_eav, e_sav, e_se, e_le}));
      check("fvh", 64'({o_f, o_v, o_h}), 64'({m_f, m_v, m_h}));
      check("line_count", 64'(o_line), 64'(m_line));
      check("pair_count", 64'(o_pair), 64'(m_pair));
      check("locked", 64'(o_locked), 64'(m_locked));
      check("pair_data", 64'({o_cb, o_y0, o_cr, o_y1}), 64'(e_pair));
      if (o_pv)  pv_seen++;
      if (o_le)  le_seen++;
      if (o_se)  se_seen++;
      if (o_sav) sav_seen++;
   endtask

   task automatic cyc(input bit e, input logic [7:0] d);
      @(negedge clk);
      en = e; din = d;
      model_step(e, d);
      @(posedge clk);
      #1 compare_all();
   endtask

   // Idle cycles carry FF on the bus to prove disabled bytes are ignored.
   task automatic put(input logic [7:0] d);
      if (gap_mode == 1) repeat ($urandom_range(0, 1)) cyc(1'b0, 8'hFF);
      else if (gap_mode == 2) cyc(1'b0, 8'hFF);
      cyc(1'b1, d);
   endtask

   task automatic send_code(input logic [7:0] xy);
      put(8'hFF); put(8'h00); put(8'h00); put(xy);
   endtask

   task automatic send_blank(input int n);
      for (int i = 0; i < n; i++) put(i[0] ? BLANK_Y : BLANK_C);
   endtask

   task automatic send_active(input int n);
      for (int i = 0; i < n; i++) put(8'($urandom_range(1, 254)));
   endtask

   task automatic send_line(input bit f, input bit v, input int n);
      send_code(xy_tab[{f, v, 1'b1}]);
      send_blank(8);
      send_code(xy_tab[{f, v, 1'b0}]);
      send_active(n);
   endtask

   initial begin
      int base;
      bit rf, rv;
      int rn;
      model_reset();
      pv_seen = 0; le_seen = 0; se_seen = 0; sav_seen = 0; gap_mode = 0;
      repeat (3) @(posedge clk);
      #1 compare_all();
      @(negedge clk) rst = 1'b0;

      // Full-length line framed by EAVs.
      send_code(8'h9D); send_blank(16); send_code(8'h80);
      base = pv_seen;
      send_active(HACT);
      send_code(8'h9D);
      check("pairs_full_line", 64'(pv_seen - base), 64'd360);
      check("len_err_full_line", 64'(le_seen), 64'd0);
      check("locked_after_line", 64'(o_locked), 64'd1);

      // Truncated line with random enable gaps.
      gap_mode = 1;
      base = pv_seen;
      send_line(0, 0, 1000);
      send_code(8'h9D);
      check("pairs_short_line", 64'(pv_seen - base), 64'd250);
      check("len_err_short_line", 64'(le_seen), 64'd1);
      send_line(0, 0, 1500);
      send_line(0, 0, 1441);
      send_code(8'h9D);
      check("len_err_long_lines", 64'(le_seen), 64'd3);

      // Corrupt XY.
      base = pv_seen;
      send_code(8'h81);
      check("sync_err_seen", 64'(se_seen), 64'd1);
      check("locked_after_bad_xy", 64'(o_locked), 64'd0);
      send_active(200);
      check("pairs_after_bad_xy", 64'(pv_seen - base), 64'd0);

      // Doubled FF preamble with enable on every other cycle.
      gap_mode = 2;
      base = sav_seen;
      put(8'hFF); put(8'hFF); put(8'h00); put(8'h00); put(8'h80);
      check("sav_toggled_en", 64'(sav_seen - base), 64'd1);
      send_active(40);
      gap_mode = 1;

      // Field sequence: F toggle resets the line count; V=1 lines emit nothing.
      send_line(0, 0, 40);
      send_code(xy_tab[3'b101]);
      check("line_after_f_toggle", 64'(o_line), 64'd0);
      send_blank(8);
      send_code(xy_tab[3'b100]);
      send_active(40);
      base = pv_seen;
      send_line(1, 1, 80);
      send_line(1, 1, 80);
      check("pairs_v1_lines", 64'(pv_seen - base), 64'd0);
      send_line(1, 0, 40);

      // Random lines.
      for (int k = 0; k < 6; k++) begin
         rf = 1'($urandom_range(0, 1));
         rv = ($urandom_range(0, 3) == 0);
         rn = ($urandom_range(0, 2) == 0) ? HACT : int'($urandom_range(0, 1500));
         gap_mode = int'($urandom_range(0, 1));
         send_line(rf, rv, rn);
      end
      send_code(xy_tab[{rf, rv, 1'b1}]);

      // Reset in the middle of an active line.
      gap_mode = 0;
      send_line(0, 0, 100);
      @(negedge clk);
      rst = 1'b1; en = 1'b0;
      model_reset();
      #1 compare_all();
      @(negedge clk) rst = 1'b0;
      base = pv_seen;
      send_active(100);
      check("pairs_after_reset", 64'(pv_seen - base), 64'd0);
      send_line(0, 0, 400);
      send_code(8'h9D);
      check("pairs_after_resync", 64'(pv_seen - base), 64'd100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
